// File: rtl/fabric_extmemory_lsq.sv
`default_nettype none
// ============================================================================
// Module   : fabric_extmemory_lsq
// Brief    : Multi-port load/store queue in front of a word-addressed memory
//            with store-to-load forwarding, deadlock watchdog and error latch.
// Revision : 1.0
// ============================================================================
module fabric_extmemory_lsq #(
    parameter int DATA_WIDTH       = 32,
    parameter int TAG_WIDTH        = 0,
    parameter int LD_COUNT         = 2,
    parameter int ST_COUNT         = 2,
    parameter int LSQ_DEPTH        = 4,
    parameter int ADDR_WIDTH       = 8,
    parameter int DEADLOCK_TIMEOUT = 65535,
    localparam int PW = DATA_WIDTH + TAG_WIDTH,
    localparam int NI = 1 + LD_COUNT + 2 * ST_COUNT,
    localparam int NO = LD_COUNT + 1 + ((ST_COUNT > 0) ? 1 : 0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NI-1:0]     in_valid,
    output logic [NI-1:0]     in_ready,
    input  logic [NI*PW-1:0]  in_data,
    output logic [NO-1:0]     out_valid,
    input  logic [NO-1:0]     out_ready,
    output logic [NO*PW-1:0]  out_data,
    output logic              error_valid,
    output logic [15:0]       error_code
);

    localparam int c_tag_w = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
    localparam int c_LDN   = (LD_COUNT > 0) ? LD_COUNT : 1;
    localparam int c_STN   = (ST_COUNT > 0) ? ST_COUNT : 1;
    localparam int c_DEPTH = (LSQ_DEPTH > 0) ? LSQ_DEPTH : 1;
    localparam int c_LPW   = (c_LDN > 1) ? $clog2(c_LDN) : 1;
    localparam int c_SPW   = (c_STN > 1) ? $clog2(c_STN) : 1;
    localparam int c_QPW   = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_CW    = $clog2(c_DEPTH + 1);
    localparam int c_NOX   = LD_COUNT + 2;
    localparam logic [15:0] c_RT_MEMORY_TAG_OOB        = 16'h0001;
    localparam logic [15:0] c_RT_MEMORY_STORE_DEADLOCK = 16'h0002;

    if (LD_COUNT + ST_COUNT == 0) begin : g_chk_ports
        $fatal(1, "fabric_extmemory_lsq: LD_COUNT+ST_COUNT must be non-zero");
    end
    if (ST_COUNT > 0 && LSQ_DEPTH < 1) begin : g_chk_depth
        $fatal(1, "fabric_extmemory_lsq: LSQ_DEPTH must be >= 1 with stores");
    end
    if (DATA_WIDTH < 1) begin : g_chk_width
        $fatal(1, "fabric_extmemory_lsq: DATA_WIDTH must be >= 1");
    end

    // Zero-padded view lets TAG_WIDTH==0 share the same extraction/packing code.
    function automatic logic [c_tag_w-1:0] f_tag(input logic [PW-1:0] word);
        logic [PW+c_tag_w-1:0] v;
        v = {{c_tag_w{1'b0}}, word};
        return v[DATA_WIDTH +: c_tag_w];
    endfunction

    function automatic logic [PW-1:0] f_pack(input logic [c_tag_w-1:0]    tag,
                                             input logic [DATA_WIDTH-1:0] word);
        logic [PW+c_tag_w-1:0] v;
        v = '0;
        v[DATA_WIDTH-1:0]         = word;
        v[DATA_WIDTH +: c_tag_w]  = tag;
        return v[PW-1:0];
    endfunction

    // Storage
    logic [DATA_WIDTH-1:0] r_mem    [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] r_q_addr [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [c_DEPTH];
    logic [c_tag_w-1:0]    r_q_tag  [c_DEPTH];
    logic [c_QPW-1:0]      r_head, r_tail;
    logic [c_CW-1:0]       r_count;

    // Output registers
    logic [c_LDN-1:0]      r_ld_valid;
    logic [PW-1:0]         r_ld_data [c_LDN];
    logic                  r_ldd_valid, r_std_valid;
    logic [PW-1:0]         r_ldd_data, r_std_data;

    logic [c_LPW-1:0]      r_ld_ptr;
    logic [c_SPW-1:0]      r_st_ptr;
    logic [15:0]           r_dl_cnt [c_STN];
    logic                  r_err_valid;
    logic [15:0]           r_err_code;

    // Request decode
    logic [ADDR_WIDTH-1:0] w_ld_addr [c_LDN];
    logic [c_tag_w-1:0]    w_ld_tag  [c_LDN];
    logic [c_LDN-1:0]      w_ld_req, w_ld_gnt;
    logic [c_LPW-1:0]      w_ld_sel;
    logic                  w_ld_any;
    logic [ADDR_WIDTH-1:0] w_st_addr [c_STN];
    logic [DATA_WIDTH-1:0] w_st_data [c_STN];
    logic [c_tag_w-1:0]    w_st_atag [c_STN];
    logic [c_tag_w-1:0]    w_st_dtag [c_STN];
    logic [c_STN-1:0]      w_st_req;
    logic [c_SPW-1:0]      w_st_sel;
    logic                  w_st_any;

    logic [c_NOX-1:0]      w_ordy;
    logic [c_NOX-1:0]      w_ov;
    logic [c_NOX*PW-1:0]   w_od;
    logic                  w_ldd_free, w_std_free;
    logic                  w_drain, w_enq;
    logic [DATA_WIDTH-1:0] w_ld_word;
    logic                  w_oob, w_dl_hit;
    logic                  w_unused;

    assign w_ordy     = c_NOX'(out_ready);
    assign w_ldd_free = !r_ldd_valid || w_ordy[LD_COUNT];
    assign w_std_free = !r_std_valid || w_ordy[LD_COUNT+1];
    assign w_drain    = (r_count != '0) && w_std_free;
    assign w_enq      = w_st_any && ((r_count < c_CW'(c_DEPTH)) || w_drain);

    always_comb begin
        w_ld_req = '0;
        for (int p = 0; p < c_LDN; p++) begin
            w_ld_addr[p] = '0;
            w_ld_tag[p]  = '0;
        end
        for (int p = 0; p < LD_COUNT; p++) begin
            w_ld_addr[p] = in_data[(1+p)*PW +: ADDR_WIDTH];
            w_ld_tag[p]  = f_tag(in_data[(1+p)*PW +: PW]);
            w_ld_req[p]  = in_valid[1+p] && (!r_ld_valid[p] || w_ordy[p]) && w_ldd_free;
        end
    end

    always_comb begin
        w_st_req = '0;
        for (int s = 0; s < c_STN; s++) begin
            w_st_addr[s] = '0;
            w_st_data[s] = '0;
            w_st_atag[s] = '0;
            w_st_dtag[s] = '0;
        end
        for (int s = 0; s < ST_COUNT; s++) begin
            w_st_addr[s] = in_data[(1+LD_COUNT+s)*PW +: ADDR_WIDTH];
            w_st_atag[s] = f_tag(in_data[(1+LD_COUNT+s)*PW +: PW]);
            w_st_data[s] = in_data[(1+LD_COUNT+ST_COUNT+s)*PW +: DATA_WIDTH];
            w_st_dtag[s] = f_tag(in_data[(1+LD_COUNT+ST_COUNT+s)*PW +: PW]);
            w_st_req[s]  = in_valid[1+LD_COUNT+s] && in_valid[1+LD_COUNT+ST_COUNT+s];
        end
    end

    // Round-robin arbiters: scan starting at the pointer, first requester wins.
    always_comb begin
        w_ld_any = 1'b0;
        w_ld_sel = '0;
        w_ld_gnt = '0;
        for (int i = 0; i < LD_COUNT; i++) begin
            int idx;
            idx = int'(r_ld_ptr) + i;
            if (idx >= LD_COUNT) idx = idx - LD_COUNT;
            if (!w_ld_any && w_ld_req[c_LPW'(idx)]) begin
                w_ld_any = 1'b1;
                w_ld_sel = c_LPW'(idx);
            end
        end
        if (w_ld_any) w_ld_gnt[w_ld_sel] = 1'b1;
    end

    always_comb begin
        w_st_any = 1'b0;
        w_st_sel = '0;
        for (int i = 0; i < ST_COUNT; i++) begin
            int idx;
            idx = int'(r_st_ptr) + i;
            if (idx >= ST_COUNT) idx = idx - ST_COUNT;
            if (!w_st_any && w_st_req[c_SPW'(idx)]) begin
                w_st_any = 1'b1;
                w_st_sel = c_SPW'(idx);
            end
        end
    end

    // Youngest matching queued store wins; the draining head is still queued here.
    always_comb begin
        logic                  hit;
        logic [DATA_WIDTH-1:0] fwd;
        hit = 1'b0;
        fwd = '0;
        for (int k = 0; k < c_DEPTH; k++) begin
            int idx;
            idx = int'(r_head) + k;
            if (idx >= c_DEPTH) idx = idx - c_DEPTH;
            if (k < int'(r_count) && r_q_addr[c_QPW'(idx)] == w_ld_addr[w_ld_sel]) begin
                hit = 1'b1;
                fwd = r_q_data[c_QPW'(idx)];
            end
        end
        w_ld_word = hit ? fwd : r_mem[w_ld_addr[w_ld_sel]];
    end

    always_comb begin
        in_ready    = '0;
        in_ready[0] = 1'b1;
        for (int p = 0; p < LD_COUNT; p++) in_ready[1+p] = w_ld_gnt[p];
        for (int s = 0; s < ST_COUNT; s++) begin
            in_ready[1+LD_COUNT+s]          = w_enq && (w_st_sel == c_SPW'(s));
            in_ready[1+LD_COUNT+ST_COUNT+s] = w_enq && (w_st_sel == c_SPW'(s));
        end
    end

    always_comb begin
        w_oob    = 1'b0;
        w_dl_hit = 1'b0;
        if (TAG_WIDTH > 0 && LD_COUNT > 1) begin
            for (int p = 0; p < LD_COUNT; p++)
                if (in_valid[1+p] && 32'(w_ld_tag[p]) >= 32'(LD_COUNT)) w_oob = 1'b1;
        end
        if (TAG_WIDTH > 0 && ST_COUNT > 1) begin
            for (int s = 0; s < ST_COUNT; s++) begin
                if (in_valid[1+LD_COUNT+s] && 32'(w_st_atag[s]) >= 32'(ST_COUNT)) w_oob = 1'b1;
                if (in_valid[1+LD_COUNT+ST_COUNT+s] && 32'(w_st_dtag[s]) >= 32'(ST_COUNT))
                    w_oob = 1'b1;
            end
        end
        for (int s = 0; s < ST_COUNT; s++)
            if (r_dl_cnt[s] == 16'(DEADLOCK_TIMEOUT)) w_dl_hit = 1'b1;
    end

    always_comb begin
        w_ov = '0;
        w_od = '0;
        for (int p = 0; p < LD_COUNT; p++) begin
            w_ov[p]          = r_ld_valid[p];
            w_od[p*PW +: PW] = r_ld_data[p];
        end
        w_ov[LD_COUNT]              = r_ldd_valid;
        w_od[LD_COUNT*PW +: PW]     = r_ldd_data;
        w_ov[LD_COUNT+1]            = r_std_valid;
        w_od[(LD_COUNT+1)*PW +: PW] = r_std_data;
    end

    assign out_valid   = w_ov[NO-1:0];
    assign out_data    = w_od[NO*PW-1:0];
    assign error_valid = r_err_valid;
    assign error_code  = r_err_code;
    assign w_unused    = ^{in_valid[0], in_data, w_ordy, w_ov, w_od};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < c_LDN; p++) r_ld_data[p] <= '0;
            for (int s = 0; s < c_STN; s++) r_dl_cnt[s] <= '0;
            r_ld_valid  <= '0;
            r_ldd_valid <= 1'b0;
            r_ldd_data  <= '0;
            r_std_valid <= 1'b0;
            r_std_data  <= '0;
            r_ld_ptr    <= '0;
            r_st_ptr    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
        end else begin
            for (int p = 0; p < LD_COUNT; p++) begin
                if (w_ld_gnt[p]) begin
                    r_ld_valid[p] <= 1'b1;
                    r_ld_data[p]  <= f_pack(w_ld_tag[p], w_ld_word);
                end else if (w_ordy[p]) begin
                    r_ld_valid[p] <= 1'b0;
                end
            end
            if (w_ld_any) begin
                r_ldd_valid <= 1'b1;
                r_ldd_data  <= (TAG_WIDTH > 0 && LD_COUNT > 1) ? f_pack(w_ld_tag[w_ld_sel], '0) : '0;
                r_ld_ptr    <= (w_ld_sel == c_LPW'(LD_COUNT - 1)) ? '0 : w_ld_sel + 1'b1;
            end else if (w_ordy[LD_COUNT]) begin
                r_ldd_valid <= 1'b0;
            end

            if (w_drain) begin
                r_std_valid <= 1'b1;
                r_std_data  <= (TAG_WIDTH > 0 && ST_COUNT > 1) ? f_pack(r_q_tag[r_head], '0) : '0;
                r_head      <= (r_head == c_QPW'(c_DEPTH - 1)) ? '0 : r_head + 1'b1;
            end else if (w_ordy[LD_COUNT+1]) begin
                r_std_valid <= 1'b0;
            end
            if (w_enq) begin
                r_tail   <= (r_tail == c_QPW'(c_DEPTH - 1)) ? '0 : r_tail + 1'b1;
                r_st_ptr <= (w_st_sel == c_SPW'(ST_COUNT - 1)) ? '0 : w_st_sel + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            for (int s = 0; s < ST_COUNT; s++) begin
                if (in_valid[1+LD_COUNT+s] ^ in_valid[1+LD_COUNT+ST_COUNT+s]) begin
                    if (r_dl_cnt[s] != 16'(DEADLOCK_TIMEOUT)) r_dl_cnt[s] <= r_dl_cnt[s] + 1'b1;
                end else begin
                    r_dl_cnt[s] <= '0;
                end
            end

            if (!r_err_valid && (w_oob || w_dl_hit)) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_oob ? c_RT_MEMORY_TAG_OOB : c_RT_MEMORY_STORE_DEADLOCK;
            end
        end
    end

    // Memory and queue payload carry no reset; only committed (drained) stores write memory.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_addr[r_tail] <= w_st_addr[w_st_sel];
            r_q_data[r_tail] <= w_st_data[w_st_sel];
            r_q_tag[r_tail]  <= w_st_atag[w_st_sel];
        end
        if (w_drain) r_mem[r_q_addr[r_head]] <= r_q_data[r_head];
    end

endmodule
`default_nettype wire

// File: tb/tb_fabric_extmemory_lsq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fabric_extmemory_lsq
// Brief    : Scoreboard bench: directed stimulus pushes expected responses,
//            a negedge monitor pops and compares on every output handshake.
// Revision : 1.0
// ============================================================================
module tb_fabric_extmemory_lsq;

    localparam int DW = 8, TW = 2, LDC = 2, STC = 2, DEP = 4, AW = 4, DLT = 16;
    localparam int PW = DW + TW;
    localparam int NI = 1 + LDC + 2 * STC;
    localparam int NO = LDC + 2;
    localparam logic [15:0] C_OOB = 16'h0001;
    localparam logic [15:0] C_DL  = 16'h0002;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NI-1:0]    in_valid, in_ready;
    logic [NI*PW-1:0] in_data;
    logic [NO-1:0]    out_valid, out_ready;
    logic [NO*PW-1:0] out_data;
    logic             error_valid;
    logic [15:0]      error_code;

    int n_cmp = 0;
    int n_bad = 0;
    logic [PW-1:0] q_ld0[$], q_ld1[$], q_ldd[$], q_std[$];

    fabric_extmemory_lsq #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .LD_COUNT(LDC), .ST_COUNT(STC),
        .LSQ_DEPTH(DEP), .ADDR_WIDTH(AW), .DEADLOCK_TIMEOUT(DLT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .error_valid(error_valid), .error_code(error_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int o, input logic [PW-1:0] act);
        logic [PW-1:0] e;
        logic ok;
        ok = 1'b1;
        e  = '0;
        case (o)
            0: if (q_ld0.size() > 0) e = q_ld0.pop_front(); else ok = 1'b0;
            1: if (q_ld1.size() > 0) e = q_ld1.pop_front(); else ok = 1'b0;
            2: if (q_ldd.size() > 0) e = q_ldd.pop_front(); else ok = 1'b0;
            default: if (q_std.size() > 0) e = q_std.pop_front(); else ok = 1'b0;
        endcase
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out%0d: unexpected output %0h", o, act);
        end else begin
            check($sformatf("out%0d", o), 32'(act), 32'(e));
        end
    endtask

    // Handshakes complete on the following posedge; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < NO; o++)
                if (out_valid[o] && out_ready[o]) pop_check(o, out_data[o*PW +: PW]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic v, input logic [TW-1:0] tag, input logic [DW-1:0] d);
        in_valid[idx]           = v;
        in_data[idx*PW +: PW]   = {tag, d};
    endtask

    task automatic wait_ready(input int idx, input string name);
        for (int n = 0; n < 50; n++) begin
            #1;
            if (in_ready[idx]) begin
                tick();
                return;
            end
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: in_ready[%0d] got 0 expected 1 within 50 cycles", name, idx);
    endtask

    task automatic do_load(input int p, input logic [TW-1:0] tag, input logic [DW-1:0] addr,
                           input logic [DW-1:0] exp_word);
        if (p == 0) q_ld0.push_back({tag, exp_word});
        else        q_ld1.push_back({tag, exp_word});
        q_ldd.push_back({tag, 8'h00});
        drive(1 + p, 1'b1, tag, addr);
        wait_ready(1 + p, "ld_grant");
        drive(1 + p, 1'b0, '0, '0);
    endtask

    task automatic do_store(input int s, input logic [TW-1:0] tag, input logic [DW-1:0] addr,
                            input logic [DW-1:0] data, input logic expect_done);
        if (expect_done) q_std.push_back({tag, 8'h00});
        drive(1 + LDC + s, 1'b1, tag, addr);
        drive(1 + LDC + STC + s, 1'b1, tag, data);
        wait_ready(1 + LDC + s, "st_enq");
        drive(1 + LDC + s, 1'b0, '0, '0);
        drive(1 + LDC + STC + s, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, prev;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_err_valid", 32'(error_valid), 0);
        check("rst_err_code", 32'(error_code), 0);
        check("memref_ready", 32'(in_ready[0]), 1);
        rst_n = 1'b1;
        tick();

        // Forwarding: first store occupies st_done, second stays queued.
        out_ready = 4'b0111;
        do_store(0, 2'd0, 8'd1, 8'h11, 1'b1);
        do_store(1, 2'd1, 8'd5, 8'hAB, 1'b1);
        tick();
        do_load(0, 2'd0, 8'd5, 8'hAB);
        check("ld_latency_valid", 32'(out_valid[0]), 1);

        // Fill queue to depth, then one drain lets one enqueue through.
        do_store(0, 2'd0, 8'd6, 8'h66, 1'b1);
        do_store(1, 2'd1, 8'd7, 8'h77, 1'b1);
        do_store(0, 2'd0, 8'd8, 8'h88, 1'b1);
        drive(4, 1'b1, 2'd1, 8'd9);
        drive(6, 1'b1, 2'd1, 8'h99);
        #1;
        check("full_addr_ready", 32'(in_ready[4]), 0);
        check("full_data_ready", 32'(in_ready[6]), 0);
        tick();
        out_ready[3] = 1'b1;
        #1;
        check("drain_enq_addr_ready", 32'(in_ready[4]), 1);
        check("drain_enq_data_ready", 32'(in_ready[6]), 1);
        q_std.push_back({2'd1, 8'h00});
        tick();
        out_ready[3] = 1'b0;
        drive(4, 1'b0, '0, '0);
        drive(6, 1'b0, '0, '0);
        drive(3, 1'b1, 2'd0, 8'd10);
        drive(5, 1'b1, 2'd0, 8'hAA);
        #1;
        check("still_full_ready", 32'(in_ready[3]), 0);
        check("st_done_held", 32'(out_valid[3]), 1);
        drive(3, 1'b0, '0, '0);
        drive(5, 1'b0, '0, '0);
        out_ready = '1;
        repeat (8) tick();
        do_load(1, 2'd1, 8'd9, 8'h99);
        do_load(0, 2'd0, 8'd8, 8'h88);
        do_load(1, 2'd1, 8'd6, 8'h66);

        // Both load ports requesting every cycle must alternate.
        drive(1, 1'b1, 2'd0, 8'd5);
        drive(2, 1'b1, 2'd1, 8'd7);
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            #1;
            g = in_ready[1] ? 0 : (in_ready[2] ? 1 : -1);
            check("rr_onehot", 32'(in_ready[1] ^ in_ready[2]), 1);
            if (g == 0) begin q_ld0.push_back({2'd0, 8'hAB}); q_ldd.push_back({2'd0, 8'h00}); end
            if (g == 1) begin q_ld1.push_back({2'd1, 8'h77}); q_ldd.push_back({2'd1, 8'h00}); end
            if (prev >= 0) check("rr_alternate", 32'(g), 32'(1 - prev));
            prev = g;
            tick();
        end
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
        tick();

        // Out-of-range load tag: flagged, yet the load still completes.
        check("err_before_oob", 32'(error_valid), 0);
        do_load(0, 2'd3, 8'd1, 8'h11);
        check("oob_err_valid", 32'(error_valid), 1);
        check("oob_err_code", 32'(error_code), 32'(C_OOB));
        repeat (3) tick();

        // Reset with three stores queued behind a blocked st_done.
        out_ready = 4'b0111;
        do_store(0, 2'd0, 8'd2, 8'h22, 1'b0);
        tick();
        do_store(1, 2'd1, 8'd5, 8'h55, 1'b0);
        do_store(0, 2'd0, 8'd9, 8'h59, 1'b0);
        do_store(1, 2'd1, 8'd1, 8'h51, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_err_valid", 32'(error_valid), 0);
        check("mid_rst_err_code", 32'(error_code), 0);
        q_std.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = '1;
        tick();
        do_load(0, 2'd0, 8'd5, 8'hAB);
        do_load(1, 2'd1, 8'd9, 8'h99);
        do_load(0, 2'd0, 8'd1, 8'h11);
        do_load(1, 2'd1, 8'd2, 8'h22);
        repeat (2) tick();

        // Lone st_addr: deadlock error one edge after the counter reaches the timeout.
        check("err_cleared", 32'(error_valid), 0);
        drive(3, 1'b1, 2'd0, 8'd3);
        repeat (DLT) tick();
        check("dl_not_early", 32'(error_valid), 0);
        tick();
        check("dl_err_valid", 32'(error_valid), 1);
        check("dl_err_code", 32'(error_code), 32'(C_DL));
        drive(3, 1'b0, '0, '0);
        repeat (5) tick();
        check("sb_leftover", 32'(q_ld0.size() + q_ld1.size() + q_ldd.size() + q_std.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
